// File: rtl/bus_receiver_pkg.sv
// rtl/bus_receiver_pkg.sv - shared defaults and pointer sizing for the bus receiver
package bus_receiver_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 4;

   // One extra bit above the address distinguishes full from empty.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/bus_rx_fifo.sv
// rtl/bus_rx_fifo.sv - first-word fall-through FIFO with wrap-bit pointers
module bus_rx_fifo
   import bus_receiver_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic             dropped
);

   localparam int PW = ptr_width(DEPTH);
   localparam int AW = PW - 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_pop;
   logic             do_push;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

   // A pop frees the slot the same-cycle push needs, so full only blocks a lone push.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dropped = push & ~do_push;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   // Masking on empty keeps stale or uninitialised storage off the output.
   assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/bus_receiver.sv
// rtl/bus_receiver.sv - tri-state bus capture into FIFO; BUS_RECEIVER_DROP_COUNT_EN adds drop_count
module bus_receiver
   import bus_receiver_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] bus_in,
   input  logic             bus_en,
   input  logic             ovf_clr,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             full,
   output logic             empty,
`ifdef BUS_RECEIVER_DROP_COUNT_EN
   output logic             overflow,
   output logic [7:0]       drop_count
`else
   output logic             overflow
`endif
);

   logic [WIDTH-1:0] cap_data;
   logic             cap_valid;
   logic             drop;

   // The bus floats when nobody drives it, so only sample under bus_en.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_data  <= '0;
         cap_valid <= 1'b0;
      end else begin
         cap_valid <= bus_en;
         if (bus_en) cap_data <= bus_in;
      end
   end

   bus_rx_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (cap_valid),
      .push_data (cap_data),
      .pop       (out_ready),
      .pop_data  (out_data),
      .full      (full),
      .empty     (empty),
      .dropped   (drop)
   );

   assign out_valid = ~empty;

   // A drop in the clearing cycle wins so no lost word goes unreported.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       overflow <= 1'b0;
      else if (drop)    overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
   end

`ifdef BUS_RECEIVER_DROP_COUNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         drop_count <= '0;
      else if (ovf_clr)
         drop_count <= drop ? 8'd1 : 8'd0;
      else if (drop && drop_count != 8'hFF)
         drop_count <= drop_count + 8'd1;
   end
`endif

endmodule
